hazard_sequencer: RTL and testbench

- Central pipeline control for the 5-stage RV32I core.
- Takes hazard sources from ID/EX/MEM:
  - load-use dependency
  - taken branch/jump resolved in EX
  - data-memory wait
- Drives per-stage register enables and flushes, sequences multi-cycle memory freezes, and keeps saturating stall/flush performance counters plus a sticky memory-timeout flag.
- Replaces ad-hoc stall wiring in the top level.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_sequencer.sv | 134 +++++++++++++
 tb/tb_hazard_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control block.
//   state_t        : sequencer state encoding (RUN / WAIT)
//   REG_X0         : architectural index of the hard-wired zero register
//   DEFAULT_CNT_W  : default width of the performance counters
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_X0        = 5'd0;
    localparam int         DEFAULT_CNT_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   en    : increment request for this edge
//   count : current value; holds at all-ones instead of wrapping
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Central pipeline control for the 5-stage RV32I core.
// Turns load-use, taken-branch and data-memory-wait hazards into per-stage
// register enables and flushes, tracks memory freezes, and keeps saturating
// stall/flush performance counters plus a sticky memory-timeout flag.
//   clk, rst           : clock, asynchronous active-high reset
//   id_rs1, id_rs2     : source registers of the instruction in ID
//   ex_rd, ex_mem_read : destination / is-load of the instruction in EX
//   ex_branch_taken    : EX resolved a taken branch or jump
//   mem_req, mem_ready : MEM access issued / completing this cycle
//   pc_en, *_en        : stage register enables
//   *_flush            : load a NOP into the named pipeline register
//   frozen             : sequencer is in WAIT
//   mem_timeout        : sticky, a freeze lasted MAX_WAIT cycles
//   stall_cnt          : cycles with pc_en low (saturating)
//   flush_cnt          : applied taken-branch flushes (saturating)
module hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             frozen,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WC_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_nxt;
    logic            freeze;
    logic            load_use;
    logic            branch_flush;

    assign freeze   = mem_req & ~mem_ready;
    assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // A freeze holds EX, so a branch seen while frozen is retried later
    // rather than counted now.
    assign branch_flush = ~rst & ~freeze & ex_branch_taken;

    // Priority mux: freeze > taken branch > load-use > normal flow.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            // The ID instruction is squashed, so any load-use on it is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        wait_nxt = '0;
        if (freeze) begin
            wait_nxt = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + WC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN:     if (freeze)  state <= WAIT;
                WAIT:    if (!freeze) state <= RUN;
                default: state <= RUN;
            endcase
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_MAX) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    assign frozen = (state == WAIT);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (~pc_en & ~rst),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (branch_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic             if_id_flush, id_ex_flush, mem_wb_flush;
    logic             frozen, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_sequencer #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .frozen          (frozen),
        .mem_timeout     (mem_timeout),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // en = {pc, if_id, id_ex, ex_mem}; fl = {if_id, id_ex, mem_wb}
    // frz/stall/flush/tmo are the values expected after the clock edge.
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [3:0] en;
        logic [2:0] fl;
        logic       frz;
        logic [3:0] stall;
        logic [3:0] flush;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic mr, input logic br,
                                input logic req, input logic rdy, input logic [3:0] en,
                                input logic [2:0] fl, input logic frz,
                                input logic [3:0] stall, input logic [3:0] flush,
                                input logic tmo);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.mr = mr; v.br = br;
        v.req = req; v.rdy = rdy; v.en = en; v.fl = fl; v.frz = frz;
        v.stall = stall; v.flush = flush; v.tmo = tmo;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mr, input logic br, input logic req, input logic rdy);
        id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_mem_read = mr; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
    endtask

    function automatic logic [3:0] en_vec();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en};
    endfunction

    function automatic logic [2:0] fl_vec();
        return {if_id_flush, id_ex_flush, mem_wb_flush};
    endfunction

    initial begin
        vec_t cur;

        //          rs1 rs2 rd mr br rq rdy  en       fl      frz stl flu tmo
        vecs.push_back(mk(1, 2, 3, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 0, 0)); // idle
        vecs.push_back(mk(1, 5, 5, 1, 0, 0, 0, 4'b0011, 3'b010, 0, 1, 0, 0)); // load-use rs2
        vecs.push_back(mk(1, 2, 3, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 1, 0, 0)); // bubble in EX
        vecs.push_back(mk(0, 2, 0, 1, 0, 0, 0, 4'b1111, 3'b000, 0, 1, 0, 0)); // x0 exempt
        vecs.push_back(mk(7, 2, 7, 1, 0, 0, 0, 4'b0011, 3'b010, 0, 2, 0, 0)); // load-use rs1
        vecs.push_back(mk(1, 5, 5, 1, 1, 0, 0, 4'b1111, 3'b110, 0, 2, 1, 0)); // branch over LU
        vecs.push_back(mk(1, 2, 3, 0, 1, 0, 0, 4'b1111, 3'b110, 0, 2, 2, 0)); // branch
        vecs.push_back(mk(1, 2, 3, 0, 0, 1, 1, 4'b1111, 3'b000, 0, 2, 2, 0)); // mem hit
        vecs.push_back(mk(1, 2, 3, 0, 0, 1, 0, 4'b0000, 3'b001, 1, 3, 2, 0)); // freeze 1
        vecs.push_back(mk(1, 2, 3, 0, 0, 1, 0, 4'b0000, 3'b001, 1, 4, 2, 0)); // freeze 2
        vecs.push_back(mk(1, 2, 3, 0, 0, 1, 0, 4'b0000, 3'b001, 1, 5, 2, 0)); // freeze 3
        vecs.push_back(mk(1, 2, 3, 0, 0, 1, 1, 4'b1111, 3'b000, 0, 5, 2, 0)); // ready
        vecs.push_back(mk(1, 2, 3, 0, 1, 1, 0, 4'b0000, 3'b001, 1, 6, 2, 0)); // branch held
        vecs.push_back(mk(1, 2, 3, 0, 1, 1, 1, 4'b1111, 3'b110, 0, 6, 3, 0)); // branch acted
        vecs.push_back(mk(1, 2, 3, 0, 0, 1, 0, 4'b0000, 3'b001, 1, 7, 3, 0)); // long freeze
        vecs.push_back(mk(1, 2, 3, 0, 0, 1, 0, 4'b0000, 3'b001, 1, 8, 3, 0));
        vecs.push_back(mk(1, 2, 3, 0, 0, 1, 0, 4'b0000, 3'b001, 1, 9, 3, 0));
        vecs.push_back(mk(1, 2, 3, 0, 0, 1, 0, 4'b0000, 3'b001, 1, 10, 3, 1)); // 4th edge
        vecs.push_back(mk(1, 2, 3, 0, 0, 1, 0, 4'b0000, 3'b001, 1, 11, 3, 1));
        vecs.push_back(mk(1, 2, 3, 0, 0, 1, 0, 4'b0000, 3'b001, 1, 12, 3, 1));
        vecs.push_back(mk(1, 2, 3, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 12, 3, 1)); // release
        vecs.push_back(mk(1, 2, 3, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 12, 3, 1)); // sticky

        // Reset: inputs would give all-enables, but rst must force zeros.
        drive(1, 2, 3, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_en", 0, 32'(en_vec()), 32'h0);
        chk("rst_fl", 0, 32'(fl_vec()), 32'h0);
        chk("rst_frozen", 0, 32'(frozen), 32'h0);
        chk("rst_tmo", 0, 32'(mem_timeout), 32'h0);
        chk("rst_stall", 0, 32'(stall_cnt), 32'h0);
        chk("rst_flush", 0, 32'(flush_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table: push expectation on drive, pop when the DUT responds.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr,
                  vecs[i].br, vecs[i].req, vecs[i].rdy);
            sb.push_back(vecs[i]);
            #1;
            cur = sb.pop_front();
            chk("en", i, 32'(en_vec()), 32'(cur.en));
            chk("flush", i, 32'(fl_vec()), 32'(cur.fl));
            @(posedge clk);
            #1;
            chk("frozen", i, 32'(frozen), 32'(cur.frz));
            chk("stall_cnt", i, 32'(stall_cnt), 32'(cur.stall));
            chk("flush_cnt", i, 32'(flush_cnt), 32'(cur.flush));
            chk("mem_timeout", i, 32'(mem_timeout), 32'(cur.tmo));
        end
        chk("sb_empty", 0, 32'(sb.size()), 32'h0);

        // Asynchronous reset in the middle of a freeze.
        @(negedge clk);
        drive(1, 2, 3, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_frozen", 0, 32'(frozen), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_frozen", 0, 32'(frozen), 32'h0);
        chk("arst_tmo", 0, 32'(mem_timeout), 32'h0);
        chk("arst_stall", 0, 32'(stall_cnt), 32'h0);
        chk("arst_flush", 0, 32'(flush_cnt), 32'h0);
        chk("arst_en", 0, 32'(en_vec()), 32'h0);
        chk("arst_fl", 0, 32'(fl_vec()), 32'h0);
        @(negedge clk);
        drive(1, 2, 3, 0, 0, 0, 0);
        rst = 1'b0;

        // Continuous load-use for 20 cycles: stall_cnt must stop at 15.
        @(negedge clk);
        drive(9, 2, 9, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("sat_pc_en", i, 32'(pc_en), 32'h0);
            @(posedge clk);
            #1;
            chk("sat_stall", i, 32'(stall_cnt), (i + 1 < 15) ? 32'(i + 1) : 32'd15);
            @(negedge clk);
        end
        drive(1, 2, 3, 0, 0, 0, 0);
        #1;
        chk("sat_release", 0, 32'(en_vec()), 32'hf);
        @(posedge clk);
        #1;
        chk("sat_hold", 0, 32'(stall_cnt), 32'd15);
        chk("sat_tmo", 0, 32'(mem_timeout), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
